fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 redirect_valid  input  1  flush and restart fetch at redirect_pc (branch/jump from execute).
REQ-006 redirect_pc  input  32  new fetch address.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  32  fetch address, word-aligned.
REQ-009 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 imem_rsp_valid  input  1  read data returned; in request order; latency of 1 or more cycles.
REQ-011 imem_rsp_data  input  32  instruction word.
REQ-012 inst_valid  output  1  queue head valid toward decode.
REQ-013 inst_ready  input  1  decode accepts the head.
REQ-014 inst  output  32  head instruction.
REQ-015 inst_pc  output  32  head instruction address.

Function
REQ-016 The block SHALL implement FSM states FETCH and DRAIN.
REQ-017 A request SHALL handshake only when imem_req_valid and imem_req_ready are both high.
REQ-018 In FETCH, imem_req_valid SHALL be high iff (queue count + outstanding) < QUEUE_DEPTH and redirect_valid is low; this rule prevents queue overflow.
REQ-019 On a request handshake, fetch_pc SHALL advance by 4, wrapping from 32'hFFFF_FFFC to 0; outstanding SHALL increment.
REQ-020 In FETCH, each response SHALL be written to the queue tail together with its PC; outstanding SHALL decrement.
REQ-021 Latency: request accepted at cycle T with 1-cycle memory means response at T+1 and inst_valid at T+2; there SHALL be no queue bypass.
REQ-022 Decode handshake (inst_valid and inst_ready) SHALL pop the head; a simultaneous push and pop SHALL leave the count unchanged.
REQ-023 With a full queue, inst_ready low SHALL hold inst and inst_pc stable.
REQ-024 redirect_valid SHALL force inst_valid and imem_req_valid low combinationally in the same cycle.
REQ-025 On redirect, the queue SHALL be flushed.
REQ-026 On redirect, fetch_pc SHALL become {redirect_pc[31:2],2'b00}.
REQ-027 On redirect, drop_cnt SHALL load the outstanding count minus any response arriving that cycle.
REQ-028 On redirect, outstanding SHALL clear.
REQ-029 On redirect, the next state SHALL be DRAIN if the loaded drop_cnt is nonzero, else FETCH.
REQ-030 In DRAIN, no requests SHALL issue.
REQ-031 In DRAIN, each response SHALL be discarded and SHALL decrement drop_cnt.
REQ-032 The FSM SHALL transition DRAIN to FETCH the cycle after drop_cnt reaches 0.
REQ-033 A redirect in DRAIN SHALL update fetch_pc only and remain in DRAIN.
REQ-034 A response with outstanding equal to 0 in FETCH SHALL be ignored.
REQ-035 The drop_cnt and outstanding counters SHALL each be $clog2(QUEUE_DEPTH)+1 bits wide.

Reset
REQ-036 On rst high at a clock edge, the state SHALL become FETCH.
REQ-037 On reset, fetch_pc SHALL load RESET_PC.
REQ-038 On reset, the queue, outstanding and drop_cnt SHALL clear.
REQ-039 While rst is high, inst_valid and imem_req_valid SHALL be 0 and inst and inst_pc SHALL be 0.
REQ-040 Reset mid-operation SHALL abandon outstanding requests without drop accounting; the memory is reset in the same cycle.
REQ-041 The first request SHALL present RESET_PC in the first cycle with rst low.

Structure
REQ-042 cpu_pkg SHALL hold t_fetch_state (FETCH, DRAIN) and t_fetch_entry (inst[31:0], pc[31:0]).
REQ-043 cpu_pkg SHALL hold the default QUEUE_DEPTH constant.
REQ-044 The queue SHALL be a sub-module fetch_fifo: a parameterised synchronous FIFO of t_fetch_entry with push, pop, flush, full, empty and count.

Verification
REQ-045 Scenario: reset release with a 1-cycle memory and inst_ready tied high -> requests at 0,4,8,..., first inst_pc 0 two cycles after the first request, then one instruction per cycle.
REQ-046 Scenario: inst_ready low for 10 cycles, depth 4 -> exactly 4 requests issued, then imem_req_valid low; entries pop in order 0,4,8,12 once ready rises.
REQ-047 Scenario: 3-cycle memory with 3 outstanding requests, redirect to 32'h100 -> 3 responses dropped, no request during DRAIN, next inst_pc 32'h100.
REQ-048 Scenario: redirect in the same cycle as a response and an inst_ready handshake -> inst_valid low that cycle, response dropped, queue empty next cycle.
REQ-049 Scenario: redirect_pc 32'h0000_0106 -> first request addr 32'h0000_0104.
REQ-050 Scenario: RESET_PC 32'hFFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000; then rst asserted mid-stream -> all outputs 0 and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
//   t_fetch_state : fetch controller states (FETCH, DRAIN)
//   t_fetch_entry : one queued instruction with its fetch address
//   FETCH_QUEUE_DEPTH : default instruction queue depth
//   word_align()  : clears the byte-offset bits of an address
package cpu_pkg;

   localparam int FETCH_QUEUE_DEPTH = 4;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } t_fetch_state;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } t_fetch_entry;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries (instruction + pc).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_push        : write i_push_data at the tail
//   i_pop         : remove the head entry
//   i_flush       : discard all entries (takes priority over push/pop)
//   o_head        : current head entry (valid when !o_empty)
//   o_full        : DEPTH entries stored
//   o_empty       : no entries stored
//   o_count       : number of stored entries
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  t_fetch_entry             i_push_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output t_fetch_entry             o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   t_fetch_entry    r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_do_push;
   logic            w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];

   assign w_do_pop  = i_pop && !o_empty;
   // a full queue can still accept a push when the head leaves in the same cycle
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // storage is not reset; the head is only observed when the count says it is valid
   always_ff @(posedge clk) begin
      if (w_do_push && !rst && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests, queues the
// returned instructions with their pcs, and hands them to decode in order.
// A redirect flushes the queue and restarts fetch; responses for requests
// still in flight at the redirect are counted and discarded in DRAIN.
//
//   state | meaning
//   FETCH | issue requests while queue + in-flight < depth, queue responses
//   DRAIN | no requests; discard drop_cnt stale responses, then return to FETCH
//
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   redirect_valid, redirect_pc     : flush and restart fetch at redirect_pc
//   imem_req_valid/addr/ready       : fetch request channel
//   imem_rsp_valid/data             : in-order read data from instruction memory
//   inst_valid/ready, inst, inst_pc : queue head toward decode
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

   t_fetch_state    r_state;
   logic [31:0]     r_fetch_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop_cnt;

   logic            w_push;
   logic            w_pop;
   t_fetch_entry    w_push_data;
   t_fetch_entry    w_head;
   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;

   logic            w_room;
   logic            w_req_hs;
   logic            w_rsp_take;
   logic [CW-1:0]   w_drop_load;
   logic [31:0]     w_redirect_pc;

   // in-flight requests reserve queue slots so a response always has a home
   assign w_room         = ({1'b0, w_count} + {1'b0, r_outstanding}) < DEPTH_W;

   assign imem_req_valid = !rst && (r_state == FETCH) && w_room && !redirect_valid;
   assign imem_req_addr  = rst ? 32'h0 : r_fetch_pc;
   assign w_req_hs       = imem_req_valid && imem_req_ready;

   // a response with nothing outstanding is spurious and is not queued
   assign w_rsp_take     = imem_rsp_valid && (r_outstanding != '0) && (r_state == FETCH);

   assign inst_valid     = !rst && !w_empty && !redirect_valid;
   assign inst           = rst ? 32'h0 : w_head.inst;
   assign inst_pc        = rst ? 32'h0 : w_head.pc;
   assign w_pop          = inst_valid && inst_ready;

   assign w_push         = !rst && !redirect_valid && w_rsp_take;
   assign w_push_data    = '{inst: imem_rsp_data, pc: r_fetch_pc - (32'(r_outstanding) << 2)};

   // a response landing in the redirect cycle is already accounted for
   assign w_drop_load    = r_outstanding - CW'(w_rsp_take);
   assign w_redirect_pc  = word_align(redirect_pc);

   fetch_fifo #(
      .DEPTH       (QUEUE_DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .i_flush     (redirect_valid),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= FETCH;
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (redirect_valid) begin
                  r_fetch_pc    <= w_redirect_pc;
                  r_drop_cnt    <= w_drop_load;
                  r_outstanding <= '0;
                  r_state       <= (w_drop_load != '0) ? DRAIN : FETCH;
               end else begin
                  if (w_req_hs) begin
                     r_fetch_pc <= r_fetch_pc + 32'd4;
                  end
                  r_outstanding <= r_outstanding + CW'(w_req_hs) - CW'(w_rsp_take);
               end
            end
            DRAIN: begin
               if (redirect_valid) begin
                  r_fetch_pc <= w_redirect_pc;
               end
               if (r_drop_cnt == '0) begin
                  if (!redirect_valid) begin
                     r_state <= FETCH;
                  end
               end else if (imem_rsp_valid) begin
                  r_drop_cnt <= r_drop_cnt - CW'(1);
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import cpu_pkg::*;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } t_mem_req;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_ready = 1'b1;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        inst_ready = 1'b0;

   logic        d0_req_valid, d1_req_valid, d0_inst_valid, d1_inst_valid;
   logic [31:0] d0_req_addr, d1_req_addr, d0_inst, d1_inst, d0_inst_pc, d1_inst_pc;

   logic        sel = 1'b0;
   logic        w_req_valid, w_inst_valid;
   logic [31:0] w_req_addr, w_inst, w_inst_pc;

   assign w_req_valid  = sel ? d1_req_valid  : d0_req_valid;
   assign w_req_addr   = sel ? d1_req_addr   : d0_req_addr;
   assign w_inst_valid = sel ? d1_inst_valid : d0_inst_valid;
   assign w_inst       = sel ? d1_inst       : d0_inst;
   assign w_inst_pc    = sel ? d1_inst_pc    : d0_inst_pc;

   fetch_unit u_dut0 (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(d0_req_valid), .imem_req_addr(d0_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(d0_inst_valid), .inst_ready(inst_ready), .inst(d0_inst), .inst_pc(d0_inst_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(d1_req_valid), .imem_req_addr(d1_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(d1_inst_valid), .inst_ready(inst_ready), .inst(d1_inst), .inst_pc(d1_inst_pc)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int lat   = 1;

   t_mem_req     mem_q[$];
   t_fetch_entry exp_q[$];
   logic [31:0]  pop_log[$];
   logic [31:0]  exp_pc = 32'h0;

   logic        last_req, last_pop, last_iv;
   logic [31:0] last_req_addr, last_pop_pc, last_inst_pc;

   // One clock cycle: memory model drives the response, outputs are sampled
   // mid-cycle, requests/pops are checked against the scoreboard, then the
   // model advances past the rising edge. Enters and leaves at a falling edge.
   task automatic cycle();
      logic         deliver;
      t_fetch_entry e;
      deliver = 1'b0;
      if (rst) begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         deliver        = 1'b1;
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = ~mem_q[0].addr;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #2;
      last_req      = w_req_valid && imem_req_ready;
      last_req_addr = w_req_addr;
      last_pop      = w_inst_valid && inst_ready;
      last_pop_pc   = w_inst_pc;
      last_iv       = w_inst_valid;
      last_inst_pc  = w_inst_pc;
      if (last_req) begin
         n_vec++;
         if (w_req_addr !== exp_pc) begin
            n_err++;
            $display("FAIL req_addr cyc=%0d got %h expected %h", cyc, w_req_addr, exp_pc);
         end
      end
      if (last_pop) begin
         n_vec++;
         pop_log.push_back(w_inst_pc);
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected cyc=%0d got pc %h expected no instruction", cyc, w_inst_pc);
         end else begin
            e = exp_q.pop_front();
            if (w_inst_pc !== e.pc || w_inst !== e.inst) begin
               n_err++;
               $display("FAIL pop_data cyc=%0d got pc %h inst %h expected pc %h inst %h",
                        cyc, w_inst_pc, w_inst, e.pc, e.inst);
            end
         end
      end
      @(posedge clk);
      if (rst) begin
         mem_q.delete();
         exp_q.delete();
         exp_pc = sel ? 32'hFFFF_FFF8 : 32'h0;
      end else begin
         if (deliver) void'(mem_q.pop_front());
         if (last_req) begin
            mem_q.push_back('{addr: last_req_addr, due: cyc + lat});
            exp_q.push_back('{inst: ~exp_pc, pc: exp_pc});
            exp_pc = exp_pc + 32'd4;
         end
         if (redirect_valid) begin
            exp_q.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic apply_reset(input logic s);
      sel = s;
      rst = 1'b1;
      redirect_valid = 1'b0;
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   task automatic wait_pop(input logic [31:0] pc, input string nm);
      int k;
      k = 0;
      do begin
         cycle();
         k++;
      end while (!last_pop && k < 20);
      n_vec++;
      if (!last_pop) begin
         n_err++;
         $display("FAIL %s_timeout got no pop in 20 cycles expected pc %h", nm, pc);
      end else if (last_pop_pc !== pc) begin
         n_err++;
         $display("FAIL %s got pc %h expected %h", nm, last_pop_pc, pc);
      end
   endtask

   task automatic test_reset();
      sel = 1'b0;
      rst = 1'b1;
      inst_ready = 1'b1;
      imem_req_ready = 1'b1;
      repeat (3) cycle();
      n_vec += 4;
      if (w_req_valid !== 1'b0)  begin n_err++; $display("FAIL rst_req_valid got %b expected 0", w_req_valid); end
      if (w_inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got %b expected 0", w_inst_valid); end
      if (w_inst !== 32'h0)      begin n_err++; $display("FAIL rst_inst got %h expected 0", w_inst); end
      if (w_inst_pc !== 32'h0)   begin n_err++; $display("FAIL rst_inst_pc got %h expected 0", w_inst_pc); end
      rst = 1'b0;
      #1;
      n_vec += 2;
      if (w_req_valid !== 1'b1)  begin n_err++; $display("FAIL first_req_valid got %b expected 1", w_req_valid); end
      if (w_req_addr !== 32'h0)  begin n_err++; $display("FAIL first_req_addr got %h expected 0", w_req_addr); end
   endtask

   task automatic test_stream();
      apply_reset(1'b0);
      lat = 1;
      inst_ready = 1'b1;
      pop_log.delete();
      for (int i = 0; i < 20; i++) begin
         cycle();
         n_vec++;
         if (last_pop !== (i >= 2)) begin
            n_err++;
            $display("FAIL stream_pop_cycle i=%0d got %b expected %b", i, last_pop, (i >= 2));
         end
      end
      n_vec++;
      if (pop_log.size() == 0 || pop_log[0] !== 32'h0) begin
         n_err++;
         $display("FAIL stream_first_pc got %h expected 0", (pop_log.size() > 0) ? pop_log[0] : 32'hX);
      end
   endtask

   task automatic test_stall();
      int nreq;
      logic [31:0] want;
      apply_reset(1'b0);
      lat = 1;
      inst_ready = 1'b0;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_req) nreq++;
         if (i >= 2) begin
            n_vec++;
            if (last_iv !== 1'b1 || last_inst_pc !== 32'h0) begin
               n_err++;
               $display("FAIL stall_head_hold i=%0d got valid %b pc %h expected 1 00000000", i, last_iv, last_inst_pc);
            end
         end
      end
      n_vec += 2;
      if (nreq != 4)        begin n_err++; $display("FAIL stall_req_count got %0d expected 4", nreq); end
      if (last_req !== 1'b0) begin n_err++; $display("FAIL stall_req_valid got %b expected 0", last_req); end
      inst_ready = 1'b1;
      pop_log.delete();
      repeat (6) cycle();
      for (int j = 0; j < 4; j++) begin
         want = 32'(j * 4);
         n_vec++;
         if (pop_log.size() <= j || pop_log[j] !== want) begin
            n_err++;
            $display("FAIL stall_pop_order j=%0d got %h expected %h", j,
                     (pop_log.size() > j) ? pop_log[j] : 32'hX, want);
         end
      end
   endtask

   task automatic test_redirect_drain();
      apply_reset(1'b0);
      lat = 3;
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_vec++;
         if (last_req !== 1'b1) begin n_err++; $display("FAIL drain_setup_req i=%0d got %b expected 1", i, last_req); end
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      cycle();
      redirect_valid = 1'b0;
      n_vec++;
      if (last_req !== 1'b0 || last_iv !== 1'b0) begin
         n_err++;
         $display("FAIL drain_redirect_mask got req %b inst_valid %b expected 0 0", last_req, last_iv);
      end
      for (int k = 0; k < 3; k++) begin
         cycle();
         n_vec++;
         if (last_req !== 1'b0) begin n_err++; $display("FAIL drain_no_req k=%0d got %b expected 0", k, last_req); end
      end
      cycle();
      n_vec++;
      if (last_req !== 1'b1 || last_req_addr !== 32'h100) begin
         n_err++;
         $display("FAIL drain_resume got req %b addr %h expected 1 00000100", last_req, last_req_addr);
      end
      wait_pop(32'h100, "drain_first_pc");
   endtask

   task automatic test_redirect_collide();
      apply_reset(1'b0);
      lat = 1;
      inst_ready = 1'b1;
      repeat (6) cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      cycle();
      redirect_valid = 1'b0;
      n_vec++;
      if (last_iv !== 1'b0 || last_req !== 1'b0) begin
         n_err++;
         $display("FAIL collide_mask got inst_valid %b req %b expected 0 0", last_iv, last_req);
      end
      cycle();
      n_vec++;
      if (last_iv !== 1'b0 || last_req !== 1'b1 || last_req_addr !== 32'h200) begin
         n_err++;
         $display("FAIL collide_after got inst_valid %b req %b addr %h expected 0 1 00000200",
                  last_iv, last_req, last_req_addr);
      end
      wait_pop(32'h200, "collide_first_pc");
   endtask

   task automatic test_misaligned();
      int k;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0106;
      cycle();
      redirect_valid = 1'b0;
      k = 0;
      do begin
         cycle();
         k++;
      end while (!last_req && k < 20);
      n_vec++;
      if (!last_req || last_req_addr !== 32'h104) begin
         n_err++;
         $display("FAIL misaligned_addr got req %b addr %h expected 1 00000104", last_req, last_req_addr);
      end
      wait_pop(32'h104, "misaligned_first_pc");
   endtask

   task automatic test_wrap();
      logic [31:0] seq [3];
      seq[0] = 32'hFFFF_FFF8;
      seq[1] = 32'hFFFF_FFFC;
      seq[2] = 32'h0000_0000;
      apply_reset(1'b1);
      lat = 1;
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_vec++;
         if (!last_req || last_req_addr !== seq[i]) begin
            n_err++;
            $display("FAIL wrap_addr i=%0d got req %b addr %h expected 1 %h", i, last_req, last_req_addr, seq[i]);
         end
      end
      repeat (3) cycle();
      rst = 1'b1;
      #1;
      n_vec++;
      if (w_req_valid !== 1'b0 || w_inst_valid !== 1'b0 || w_inst !== 32'h0 ||
          w_inst_pc !== 32'h0 || w_req_addr !== 32'h0) begin
         n_err++;
         $display("FAIL midrst_outputs got rv %b ra %h iv %b inst %h pc %h expected all 0",
                  w_req_valid, w_req_addr, w_inst_valid, w_inst, w_inst_pc);
      end
      cycle();
      rst = 1'b0;
      #1;
      n_vec++;
      if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFF8) begin
         n_err++;
         $display("FAIL midrst_restart got req %b addr %h expected 1 fffffff8", w_req_valid, w_req_addr);
      end
      wait_pop(32'hFFFF_FFF8, "midrst_first_pc");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drain();
      test_redirect_collide();
      test_misaligned();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
